wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, result data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, entries per unit queue (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports au_valid / mul_valid / lsu_valid, input, 1 each, unit result offered this cycle.
REQ-006 SHALL have ports au_data / mul_data / lsu_data, input, XLEN each, unit result.
REQ-007 SHALL have ports au_rd / mul_rd / lsu_rd, input, 5 each, destination register.
REQ-008 SHALL have ports au_ready / mul_ready / lsu_ready, output, 1 each, unit queue can accept.
REQ-009 SHALL have ports au_result / mul_result / lsu_result, output, XLEN each, registered data toward the writeback select mux.
REQ-010 SHALL have port wb_select, output, 3, one-hot source: 3'b100 AU, 3'b010 MUL, 3'b001 LSU, 3'b000 idle.
REQ-011 SHALL have port wb_rd, output, 5, destination register of selected result.
REQ-012 SHALL have port wb_we, output, 1, register-file write enable.

Function
REQ-013 SHALL enqueue unit X result (data, rd) on a rising edge where X_valid and X_ready are both high.
REQ-014 SHALL drive X_ready high iff X's queue holds fewer than FIFO_DEPTH entries; a same-cycle pop SHALL NOT raise ready while full.
REQ-015 SHALL preserve per-unit order; no ordering guarantee across units.
REQ-016 SHALL each cycle grant at most one non-empty queue using round-robin, order AU -> MUL -> LSU -> AU, starting after the last granted unit.
REQ-017 SHALL, after reset, treat LSU as last granted (AU highest priority first).
REQ-018 SHALL pop the granted entry and load output registers on the same edge; result visible the following cycle.
REQ-019 SHALL give latency of 2 cycles: accepted at edge N, earliest wb_select non-zero in the cycle after edge N+1.
REQ-020 SHALL set wb_select to the one-hot code of the granted unit, 3'b000 when no grant.
REQ-021 SHALL drive the selected unit's *_result with granted data and the other two *_result with zero.
REQ-022 SHALL drive wb_we = grant AND (rd != 0); an rd=0 entry SHALL still be consumed with wb_select set.
REQ-023 SHALL hold wb_rd at granted rd, zero when idle.
REQ-024 SHALL sustain one writeback per cycle while any queue is non-empty.
REQ-025 SHALL allow push into an empty queue and grant of that queue to be independent: entry pushed at edge N is grantable no earlier than edge N+1 (no bypass).
REQ-026 SHALL allow simultaneous push and pop on a non-full queue, count unchanged.

Reset
REQ-027 SHALL on rst clear all queues (counts zero, pointers zero), round-robin pointer to LSU, all outputs zero, *_ready zero during rst cycle.
REQ-028 SHALL discard in-flight entries when rst asserts mid-operation; no writeback for them after reset.
REQ-029 SHALL assert *_ready the first cycle after rst deasserts.

Structure
REQ-030 SHALL place XLEN default, the three one-hot select codes and the unit index encoding in the shared package.
REQ-031 SHALL instantiate sub-module wb_fifo (XLEN+5 bits wide, FIFO_DEPTH deep, push/pop/full/empty) three times.
REQ-032 SHALL keep arbitration and output registers in wb_arbiter; outputs registered, no combinational input-to-output path.

Verification
REQ-033 SHALL test single AU result data=0x0000_1234 rd=5 at edge 1 -> cycle after edge 2: wb_select=3'b100, au_result=0x1234, wb_rd=5, wb_we=1, others zero.
REQ-034 SHALL test all three valid in same cycle -> three consecutive writebacks AU, MUL, LSU, then wb_select=0.
REQ-035 SHALL test MUL valid held 4 cycles with no other traffic -> mul_ready low after 2 accepts until pops free space; 4 writebacks in order.
REQ-036 SHALL test LSU result rd=0 data=0xDEAD_BEEF -> wb_select=3'b001, lsu_result=0xDEADBEEF, wb_we=0.
REQ-037 SHALL test all queues continuously fed -> grants rotate AU,MUL,LSU,AU..., no starvation over 30 cycles.
REQ-038 SHALL test rst asserted with 2 entries queued per unit -> outputs zero next cycle, no further writebacks.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default width, one-hot select
// codes and the unit index encoding used for round-robin arbitration.
package wb_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RD_W         = 5;

    localparam logic [2:0] SEL_AU   = 3'b100;
    localparam logic [2:0] SEL_MUL  = 3'b010;
    localparam logic [2:0] SEL_LSU  = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

    typedef enum logic [1:0] {
        UNIT_AU  = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_LSU = 2'd2
    } unit_e;

    // Round-robin successor: AU -> MUL -> LSU -> AU.
    function automatic unit_e next_unit(unit_e u);
        case (u)
            UNIT_AU:  return UNIT_MUL;
            UNIT_MUL: return UNIT_LSU;
            default:  return UNIT_AU;
        endcase
    endfunction

    function automatic logic [2:0] sel_code(unit_e u);
        case (u)
            UNIT_AU:  return SEL_AU;
            UNIT_MUL: return SEL_MUL;
            UNIT_LSU: return SEL_LSU;
            default:  return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-unit result queue: synchronous FIFO with registered occupancy, so full
// never drops in the same cycle as a pop.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues results from AU, MUL and LSU and grants one per
// cycle round-robin into registered writeback outputs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            au_valid,
    input  logic [XLEN-1:0] au_data,
    input  logic [4:0]      au_rd,
    input  logic            mul_valid,
    input  logic [XLEN-1:0] mul_data,
    input  logic [4:0]      mul_rd,
    input  logic            lsu_valid,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [4:0]      lsu_rd,
    output logic            au_ready,
    output logic            mul_ready,
    output logic            lsu_ready,
    output logic [XLEN-1:0] au_result,
    output logic [XLEN-1:0] mul_result,
    output logic [XLEN-1:0] lsu_result,
    output logic [2:0]      wb_select,
    output logic [4:0]      wb_rd,
    output logic            wb_we
);

    localparam int EW = XLEN + RD_W;

    logic [2:0]    in_valid;
    logic [EW-1:0] in_entry [3];
    logic [EW-1:0] head     [3];
    logic [2:0]    full_v;
    logic [2:0]    empty_v;
    logic [2:0]    ready_v;
    logic [2:0]    push_v;
    logic [2:0]    pop_v;

    unit_e         last_grant;
    unit_e         grant_unit;
    unit_e         cand;
    logic          grant_valid;
    logic [EW-1:0] grant_entry;
    logic [XLEN-1:0] grant_data;
    logic [4:0]    grant_rd;

    assign in_valid    = {lsu_valid, mul_valid, au_valid};
    assign in_entry[0] = {au_rd, au_data};
    assign in_entry[1] = {mul_rd, mul_data};
    assign in_entry[2] = {lsu_rd, lsu_data};

    // Ready is held low while reset is asserted, independent of queue state.
    assign ready_v   = rst ? 3'b000 : ~full_v;
    assign push_v    = in_valid & ready_v;
    assign au_ready  = ready_v[0];
    assign mul_ready = ready_v[1];
    assign lsu_ready = ready_v[2];

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        wb_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_v[g]),
            .push_data (in_entry[g]),
            .pop       (pop_v[g]),
            .pop_data  (head[g]),
            .full      (full_v[g]),
            .empty     (empty_v[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= UNIT_LSU;
        end else if (grant_valid) begin
            last_grant <= grant_unit;
        end
    end

    // Scan the three units starting just after the last granted one.
    always_comb begin
        grant_valid = 1'b0;
        grant_unit  = UNIT_AU;
        cand        = last_grant;
        for (int k = 0; k < 3; k++) begin
            cand = next_unit(cand);
            if (!grant_valid && !empty_v[cand]) begin
                grant_valid = 1'b1;
                grant_unit  = cand;
            end
        end
    end

    always_comb begin
        pop_v = 3'b000;
        if (grant_valid) begin
            pop_v[grant_unit] = 1'b1;
        end
    end

    assign grant_entry = head[grant_unit];
    assign grant_data  = grant_entry[XLEN-1:0];
    assign grant_rd    = grant_entry[EW-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst || !grant_valid) begin
            wb_select  <= SEL_NONE;
            wb_rd      <= '0;
            wb_we      <= 1'b0;
            au_result  <= '0;
            mul_result <= '0;
            lsu_result <= '0;
        end else begin
            wb_select  <= sel_code(grant_unit);
            wb_rd      <= grant_rd;
            wb_we      <= (grant_rd != '0);
            au_result  <= (grant_unit == UNIT_AU)  ? grant_data : '0;
            mul_result <= (grant_unit == UNIT_MUL) ? grant_data : '0;
            lsu_result <= (grant_unit == UNIT_LSU) ? grant_data : '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based round-robin reference model.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int EW    = XLEN + 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]      v;
    logic [XLEN-1:0] d   [3];
    logic [4:0]      r   [3];
    logic [2:0]      rdy;
    logic [XLEN-1:0] res [3];
    logic [2:0]      wb_select;
    logic [4:0]      wb_rd;
    logic            wb_we;

    wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .au_valid   (v[0]),
        .au_data    (d[0]),
        .au_rd      (r[0]),
        .mul_valid  (v[1]),
        .mul_data   (d[1]),
        .mul_rd     (r[1]),
        .lsu_valid  (v[2]),
        .lsu_data   (d[2]),
        .lsu_rd     (r[2]),
        .au_ready   (rdy[0]),
        .mul_ready  (rdy[1]),
        .lsu_ready  (rdy[2]),
        .au_result  (res[0]),
        .mul_result (res[1]),
        .lsu_result (res[2]),
        .wb_select  (wb_select),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we)
    );

    // Reference model: one queue of {rd,data} per unit, index 0=AU 1=MUL 2=LSU.
    logic [EW-1:0]   exp_q_au[$];
    logic [EW-1:0]   exp_q_mul[$];
    logic [EW-1:0]   exp_q_lsu[$];
    int              last_u;
    logic [2:0]      exp_sel;
    logic [XLEN-1:0] exp_res [3];
    logic [4:0]      exp_rd;
    logic            exp_we;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int qsize(input int u);
        case (u)
            0:       return exp_q_au.size();
            1:       return exp_q_mul.size();
            default: return exp_q_lsu.size();
        endcase
    endfunction

    function automatic void qpush(input int u, input logic [EW-1:0] e);
        case (u)
            0:       exp_q_au.push_back(e);
            1:       exp_q_mul.push_back(e);
            default: exp_q_lsu.push_back(e);
        endcase
    endfunction

    function automatic logic [EW-1:0] qpop(input int u);
        case (u)
            0:       return exp_q_au.pop_front();
            1:       return exp_q_mul.pop_front();
            default: return exp_q_lsu.pop_front();
        endcase
    endfunction

    task automatic model_clear_outputs();
        exp_sel = 3'b000;
        exp_rd  = '0;
        exp_we  = 1'b0;
        for (int i = 0; i < 3; i++) exp_res[i] = '0;
    endtask

    // Applies one rising edge to the model using the inputs driven before it.
    task automatic model_edge();
        bit            acc [3];
        bit            found;
        int            u;
        logic [EW-1:0] e;
        model_clear_outputs();
        if (rst) begin
            exp_q_au.delete();
            exp_q_mul.delete();
            exp_q_lsu.delete();
            last_u = 2;
        end else begin
            for (int i = 0; i < 3; i++) acc[i] = v[i] && (qsize(i) < DEPTH);
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                u = (last_u + k) % 3;
                if (!found && qsize(u) > 0) begin
                    found      = 1'b1;
                    e          = qpop(u);
                    exp_sel    = 3'b100 >> u;
                    exp_res[u] = e[XLEN-1:0];
                    exp_rd     = e[EW-1:XLEN];
                    exp_we     = (e[EW-1:XLEN] != 5'd0);
                    last_u     = u;
                end
            end
            for (int i = 0; i < 3; i++) if (acc[i]) qpush(i, {r[i], d[i]});
        end
    endtask

    task automatic check_ready();
        check("au_ready",  {63'd0, rdy[0]}, {63'd0, !rst && (qsize(0) < DEPTH)});
        check("mul_ready", {63'd0, rdy[1]}, {63'd0, !rst && (qsize(1) < DEPTH)});
        check("lsu_ready", {63'd0, rdy[2]}, {63'd0, !rst && (qsize(2) < DEPTH)});
    endtask

    task automatic check_outputs();
        check("wb_select",  {61'd0, wb_select}, {61'd0, exp_sel});
        check("wb_rd",      {59'd0, wb_rd},     {59'd0, exp_rd});
        check("wb_we",      {63'd0, wb_we},     {63'd0, exp_we});
        check("au_result",  {32'd0, res[0]},    {32'd0, exp_res[0]});
        check("mul_result", {32'd0, res[1]},    {32'd0, exp_res[1]});
        check("lsu_result", {32'd0, res[2]},    {32'd0, exp_res[2]});
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic cycle();
        #1;
        check_ready();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            d[i] = '0;
            r[i] = '0;
        end
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drive_random(input int u);
        d[u] = $urandom;
        r[u] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endtask

    initial begin
        rst    = 1'b1;
        last_u = 2;
        idle_inputs();
        model_clear_outputs();
        reset_dut();
        cycle();

        // Single AU result, visible two edges after acceptance.
        v[0] = 1'b1; d[0] = 32'h0000_1234; r[0] = 5'd5;
        cycle();
        idle_inputs();
        cycle();
        check("single_sel", {61'd0, wb_select}, 64'h4);
        check("single_au",  {32'd0, res[0]},    64'h1234);
        check("single_rd",  {59'd0, wb_rd},     64'd5);
        check("single_we",  {63'd0, wb_we},     64'd1);
        check("single_mul", {32'd0, res[1]},    64'd0);
        cycle();

        // All three units at once: AU, MUL, LSU, then idle.
        reset_dut();
        v = 3'b111;
        for (int i = 0; i < 3; i++) drive_random(i);
        cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("burst_order", {61'd0, wb_select}, {61'd0, (k < 3) ? (3'b100 >> k) : 3'b000});
        end

        // MUL alone, valid held until four results are accepted.
        begin
            int accepted = 0;
            v[1] = 1'b1;
            drive_random(1);
            for (int k = 0; k < 12 && accepted < 4; k++) begin
                if (!rst && qsize(1) < DEPTH) accepted++;
                cycle();
                if (accepted >= 4) v[1] = 1'b0;
                drive_random(1);
            end
            check("mul_accepts", 64'(accepted), 64'd4);
            idle_inputs();
            for (int k = 0; k < 4; k++) cycle();
        end

        // LSU writing x0: selected but no register write.
        v[2] = 1'b1; d[2] = 32'hDEAD_BEEF; r[2] = 5'd0;
        cycle();
        idle_inputs();
        cycle();
        check("x0_sel", {61'd0, wb_select}, 64'h1);
        check("x0_lsu", {32'd0, res[2]},    64'hDEAD_BEEF);
        check("x0_we",  {63'd0, wb_we},     64'd0);

        // Continuous feed on all units: strict rotation, no starvation.
        begin
            int grants [3];
            reset_dut();
            for (int i = 0; i < 3; i++) grants[i] = 0;
            v = 3'b111;
            for (int i = 0; i < 3; i++) drive_random(i);
            cycle();
            for (int k = 0; k < 30; k++) begin
                for (int i = 0; i < 3; i++) drive_random(i);
                cycle();
                check("rotate", {61'd0, wb_select}, {61'd0, 3'b100 >> (k % 3)});
                for (int i = 0; i < 3; i++) if (wb_select[2-i]) grants[i]++;
            end
            for (int i = 0; i < 3; i++) check("fair_share", 64'(grants[i]), 64'd10);
        end

        // Reset with queues populated: nothing drains afterwards.
        reset_dut();
        v = 3'b111;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) drive_random(i);
            cycle();
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        check("rst_sel", {61'd0, wb_select}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("post_rst_sel", {61'd0, wb_select}, 64'd0);
            check("post_rst_we",  {63'd0, wb_we},     64'd0);
        end

        // Random traffic with occasional mid-run resets.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 3; i++) begin
                v[i] = ($urandom_range(0, 2) != 0);
                drive_random(i);
            end
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 8; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
